// File: rtl/instruction_fetch_unit_pkg.sv
// Purpose: shared types and defaults for the instruction fetch unit and its buffer.
// Latency: n/a (types, constants and a pure address-clamp helper only).
// Backpressure: n/a.
package instruction_fetch_unit_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned IFU_DEPTH      = 2;
    localparam logic [31:0] IFU_ADDR_LIMIT = 32'd252;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // no request outstanding
        ST_REQ   = 2'd1,  // request outstanding, response will be kept
        ST_DRAIN = 2'd2   // request outstanding, response will be dropped
    } fetch_state_t;

    // One buffer entry: fetch address in the upper word, instruction in the lower.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    // Word-align a fetch address; anything past the legal range fetches from 0.
    function automatic logic [WORD_W-1:0] clamp_addr(input logic [WORD_W-1:0] pc,
                                                     input logic [WORD_W-1:0] limit);
        if (pc <= limit) begin
            return {pc[WORD_W-1:2], 2'b00};
        end
        return '0;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Purpose: DEPTH-entry, 64-bit FIFO holding fetched {pc, instr} pairs for decode.
// Latency: push visible at the head the cycle after it is written; head is read combinationally.
// Backpressure: none internally; the writer must never push when full, pop on empty is ignored.
// Ports: core_clk/arst_n, push_vld/push_dat write, pop_vld read, clear (sync, overrides push/pop),
//        count (occupancy 0..DEPTH), head_dat (oldest entry, zero after reset).
module fetch_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       core_clk,
    input  logic                       arst_n,
    input  logic                       push_vld,
    input  logic [63:0]                push_dat,
    input  logic                       pop_vld,
    input  logic                       clear,
    output logic [$clog2(DEPTH):0]     count,
    output logic [63:0]                head_dat
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    // A pop on an empty buffer would corrupt the pointers, so it is dropped here.
    assign do_pop   = pop_vld && (count != '0);
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the natural pointer wrap is modulo DEPTH.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_vld, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Purpose: single-outstanding instruction fetcher feeding a small decode buffer.
// Latency: request one cycle after issue decision; buffered instr visible the cycle after MemAck.
// Backpressure: stops issuing while the buffer is full; DecodeReady low simply holds the head.
// Ports: Clock/Reset (async, active-low), PC in / PCWriteEnable pulse out, Flush redirect,
//        MemReq/MemAddr/MemAck/MemData memory port, InstrValid/Instr/InstrPC/DecodeReady decode port.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH      = IFU_DEPTH,
    parameter logic [31:0] ADDR_LIMIT = IFU_ADDR_LIMIT
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] PC,
    output logic        PCWriteEnable,
    input  logic        Flush,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemAck,
    input  logic [31:0] MemData,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    input  logic        DecodeReady
);

    localparam int unsigned      CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic              started;
    logic              issue;
    logic              accept;
    logic [31:0]       mem_addr;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    logic [63:0]       head_dat;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Only one request is ever in flight, so a free slot at issue time
                // guarantees room for its response. 'started' holds off the very
                // first cycle after reset release. MemAck here is stale and ignored.
                if (started && !Flush && (count < DEPTH_CNT)) begin
                    state_nxt = ST_REQ;
                    issue     = 1'b1;
                end
            end
            ST_REQ: begin
                if (MemAck) begin
                    state_nxt = ST_IDLE;
                    accept    = !Flush;
                end else if (Flush) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The redirected response still has to come back before a new
                // request can go out; its data is dropped.
                if (MemAck) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            started  <= 1'b0;
            mem_addr <= '0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
            if (issue) begin
                mem_addr <= clamp_addr(PC, ADDR_LIMIT);
            end
        end
    end

    assign MemReq        = (state != ST_IDLE);
    assign MemAddr       = mem_addr;
    assign PCWriteEnable = accept;

    assign push_entry.pc    = mem_addr;
    assign push_entry.instr = MemData;
    assign head_entry       = fetch_entry_t'(head_dat);

    assign InstrValid = (count != '0);
    assign Instr      = head_entry.instr;
    assign InstrPC    = head_entry.pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .core_clk (Clock),
        .arst_n   (Reset),
        .push_vld (accept),
        .push_dat (push_entry),
        .pop_vld  (InstrValid && DecodeReady),
        .clear    (Flush),
        .count    (count),
        .head_dat (head_dat)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        Clock;
    logic        Reset;
    logic [31:0] PC;
    logic        PCWriteEnable;
    logic        Flush;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemData;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        DecodeReady;

    int total = 0;
    int bad   = 0;

    instruction_fetch_unit dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .PC            (PC),
        .PCWriteEnable (PCWriteEnable),
        .Flush         (Flush),
        .MemReq        (MemReq),
        .MemAddr       (MemAddr),
        .MemAck        (MemAck),
        .MemData       (MemData),
        .InstrValid    (InstrValid),
        .Instr         (Instr),
        .InstrPC       (InstrPC),
        .DecodeReady   (DecodeReady)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b0; PC = 32'h0; Flush = 1'b0; MemAck = 1'b1; MemData = 32'hDEADBEEF;
        DecodeReady = 1'b0;

        // Reset state (stray MemAck must not create a pulse)
        tick(); tick();
        chk("rst_memreq", MemReq, 0);
        chk("rst_memaddr", MemAddr, 0);
        chk("rst_valid", InstrValid, 0);
        chk("rst_instr", Instr, 0);
        chk("rst_instrpc", InstrPC, 0);
        chk("rst_pcwe", PCWriteEnable, 0);

        // Basic fetch, PC=0x10, ack one cycle after request
        MemAck = 1'b0; PC = 32'h10; DecodeReady = 1'b1;
        Reset = 1'b1;
        tick();
        chk("first_edge_no_req", MemReq, 0);
        tick();
        chk("basic_memreq", MemReq, 1);
        chk("basic_memaddr", MemAddr, 32'h10);
        chk("basic_pcwe_before_ack", PCWriteEnable, 0);
        MemAck = 1'b1; MemData = 32'h8C010004;
        #1;
        chk("basic_pcwe", PCWriteEnable, 1);
        tick();
        MemAck = 1'b0;
        #1;
        chk("basic_pcwe_off", PCWriteEnable, 0);
        chk("basic_memreq_off", MemReq, 0);
        chk("basic_valid", InstrValid, 1);
        chk("basic_instr", Instr, 32'h8C010004);
        chk("basic_instrpc", InstrPC, 32'h10);

        // Backpressure: pop previous, then fill buffer from PC 0 and 4
        PC = 32'h0;
        tick();
        chk("bp_popped", InstrValid, 0);
        chk("bp_req0", MemReq, 1);
        chk("bp_addr0", MemAddr, 32'h0);
        DecodeReady = 1'b0;
        MemAck = 1'b1; MemData = 32'hA0000000;
        #1;
        chk("bp_pcwe0", PCWriteEnable, 1);
        tick();
        MemAck = 1'b0; PC = 32'h4;
        #1;
        chk("bp_valid0", InstrValid, 1);
        chk("bp_idle_gap", MemReq, 0);
        tick();
        chk("bp_req4", MemReq, 1);
        chk("bp_addr4", MemAddr, 32'h4);
        MemAck = 1'b1; MemData = 32'hA0000004;
        tick();
        MemAck = 1'b0; PC = 32'h8;
        tick();
        chk("bp_full_noreq_a", MemReq, 0);
        chk("bp_count2", 32'(dut.u_fifo.count), 2);
        tick();
        chk("bp_full_noreq_b", MemReq, 0);
        chk("bp_head_instr0", Instr, 32'hA0000000);
        chk("bp_head_pc0", InstrPC, 32'h0);
        DecodeReady = 1'b1;
        tick();
        chk("bp_head_instr4", Instr, 32'hA0000004);
        chk("bp_head_pc4", InstrPC, 32'h4);
        chk("bp_still_noreq", MemReq, 0);
        tick();
        chk("bp_empty", InstrValid, 0);
        chk("bp_resume_req", MemReq, 1);
        chk("bp_resume_addr", MemAddr, 32'h8);

        // Serve PC 8, then out-of-range PC 0x100 clamps to 0
        DecodeReady = 1'b0;
        MemAck = 1'b1; MemData = 32'h000000B8;
        tick();
        MemAck = 1'b0; PC = 32'h100;
        tick();
        chk("clamp_memaddr", MemAddr, 32'h0);
        chk("clamp_memreq", MemReq, 1);
        MemAck = 1'b1; MemData = 32'h000000CC;
        tick();
        MemAck = 1'b0;
        #1;
        chk("wrap_head_b8", Instr, 32'h000000B8);
        DecodeReady = 1'b1;
        tick();
        DecodeReady = 1'b0;
        #1;
        chk("clamp_instr", Instr, 32'h000000CC);
        chk("clamp_instrpc", InstrPC, 32'h0);
        PC = 32'h20;
        tick();
        chk("refill_addr", MemAddr, 32'h20);
        MemAck = 1'b1; MemData = 32'h000000DD;
        tick();
        MemAck = 1'b0;

        // Flush with MemAck on a full buffer: cleared, no push, no pulse
        chk("full_before_flush", 32'(dut.u_fifo.count), 2);
        Flush = 1'b1; MemAck = 1'b1; MemData = 32'h000000EE;
        #1;
        chk("flush_full_pcwe", PCWriteEnable, 0);
        tick();
        Flush = 1'b0; MemAck = 1'b0;
        #1;
        chk("flush_full_count0", 32'(dut.u_fifo.count), 0);
        chk("flush_full_valid", InstrValid, 0);
        chk("flush_full_noreq", MemReq, 0);

        // Flush and MemAck together while a request is outstanding
        tick();
        chk("fa_req", MemReq, 1);
        chk("fa_addr", MemAddr, 32'h20);
        Flush = 1'b1; MemAck = 1'b1; MemData = 32'h000000FF;
        #1;
        chk("fa_pcwe", PCWriteEnable, 0);
        tick();
        Flush = 1'b0; MemAck = 1'b0;
        #1;
        chk("fa_valid", InstrValid, 0);
        chk("fa_idle", MemReq, 0);

        // Flush while waiting: DRAIN, drop response, new PC used after
        tick();
        chk("drain_req", MemReq, 1);
        tick();
        chk("drain_wait_addr", MemAddr, 32'h20);
        tick();
        Flush = 1'b1; PC = 32'h40;
        #1;
        chk("drain_flush_pcwe", PCWriteEnable, 0);
        tick();
        Flush = 1'b0;
        #1;
        chk("drain_memreq_held", MemReq, 1);
        tick();
        chk("drain_memreq_held2", MemReq, 1);
        MemAck = 1'b1; MemData = 32'h00000011;
        #1;
        chk("drain_ack_pcwe", PCWriteEnable, 0);
        tick();
        MemAck = 1'b0;
        #1;
        chk("drain_valid", InstrValid, 0);
        chk("drain_idle", MemReq, 0);
        tick();
        chk("drain_new_req", MemReq, 1);
        chk("drain_new_addr", MemAddr, 32'h40);

        // Reset mid-request, then a stale MemAck in IDLE
        Reset = 1'b0;
        #1;
        chk("midrst_memreq", MemReq, 0);
        chk("midrst_memaddr", MemAddr, 0);
        tick();
        Reset = 1'b1;
        MemAck = 1'b1; MemData = 32'h00000099;
        #1;
        chk("stale_pcwe", PCWriteEnable, 0);
        tick();
        MemAck = 1'b0;
        #1;
        chk("stale_valid", InstrValid, 0);
        chk("stale_noreq", MemReq, 0);
        tick();
        chk("stale_valid_after", InstrValid, 0);
        chk("post_rst_req", MemReq, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-002 Parameter ADDR_LIMIT, default 252, highest legal byte fetch address.
REQ-003 Clock  input  1  single clock; all state updates on posedge Clock.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 PC  input  32  current fetch address from the program counter register.
REQ-006 PCWriteEnable  output  1  one-cycle pulse telling the program counter to load its next address.
REQ-007 Flush  input  1  PC redirected this cycle; discard buffered and in-flight instructions.
REQ-008 MemReq  output  1  instruction memory read request.
REQ-009 MemAddr  output  32  registered word-aligned read address.
REQ-010 MemAck  input  1  memory response valid; MemData valid same cycle.
REQ-011 MemData  input  32  instruction word returned by memory.
REQ-012 InstrValid  output  1  buffer head holds an instruction for decode.
REQ-013 Instr  output  32  buffer head instruction word.
REQ-014 InstrPC  output  32  byte address the head instruction was fetched from.
REQ-015 DecodeReady  input  1  decode accepts head when InstrValid is high.

Function
REQ-016 FSM states: IDLE, REQ (request outstanding), DRAIN (discarding in-flight response after Flush).
REQ-017 IDLE -> REQ when buffer count < DEPTH and Flush low; MemReq rises next cycle, MemAddr latched from PC.
REQ-018 Latched MemAddr = {PC[31:2],2'b00} if PC <= ADDR_LIMIT, else 0.
REQ-019 In REQ, MemReq and MemAddr held stable until MemAck; arbitrary wait states tolerated.
REQ-020 REQ with MemAck and Flush low: push {MemAddr, MemData}, PCWriteEnable=1 that cycle (combinational), go IDLE; MemReq low next cycle.
REQ-021 PCWriteEnable is low in every other case, including all cycles with Flush high.
REQ-022 REQ with Flush high and MemAck low: go DRAIN, MemReq stays high until MemAck.
REQ-023 REQ with Flush and MemAck both high: response discarded, go IDLE, no push, no PCWriteEnable.
REQ-024 DRAIN: on MemAck discard data, go IDLE; Flush in DRAIN keeps DRAIN.
REQ-025 MemAck in IDLE ignored.
REQ-026 Issue rule guarantees push never finds the buffer full; count never exceeds DEPTH.
REQ-027 InstrValid = (count != 0); pop on InstrValid && DecodeReady.
REQ-028 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-029 Flush clears count and both pointers next cycle, overriding same-cycle push and pop.
REQ-030 Pointers wrap modulo DEPTH; FIFO order strictly preserved.
REQ-031 Zero-wait memory gives one instruction per two cycles steady state.

Reset
REQ-032 Reset low: FSM IDLE, count and pointers 0, MemReq 0, MemAddr 0, buffer storage 0.
REQ-033 During reset InstrValid 0, Instr 0, InstrPC 0, PCWriteEnable 0.
REQ-034 Reset mid-request abandons the request; a later stale MemAck lands in IDLE and is ignored.
REQ-035 First request issues no earlier than the second posedge after Reset deasserts.

Structure
REQ-036 Shared package holds FSM state enum, DEPTH and ADDR_LIMIT defaults, 32-bit word width constant.
REQ-037 Buffer implemented as sub-module fetch_fifo (64-bit entries, push/pop/clear, count, head outputs).
REQ-038 FSM, address clamp and PCWriteEnable logic live in instruction_fetch_unit.

Verification
REQ-039 Reset release, PC=0x10, MemAck one cycle after MemReq, MemData=0x8C010004, DecodeReady=1 -> MemAddr=0x10, one PCWriteEnable pulse, InstrValid with Instr=0x8C010004, InstrPC=0x10.
REQ-040 DecodeReady=0, PC stepping 0,4,8, zero-wait memory -> two pushes then MemReq stays low; count=2; DecodeReady=1 resumes in order 0,4.
REQ-041 PC=0x100 (>252) -> MemAddr=0x0, InstrPC=0x0.
REQ-042 Flush while MemReq waiting 3 cycles -> DRAIN, MemAck data discarded, no PCWriteEnable, InstrValid 0, next request uses new PC.
REQ-043 Flush and MemAck same cycle with full buffer -> count 0 next cycle, no push, no PCWriteEnable.
REQ-044 Reset asserted mid-REQ, MemAck pulsed after release in IDLE -> no push, InstrValid stays 0.
